// File: rtl/coeff_pair_streamer.sv
// coeff_pair_streamer
// Captures the even/odd coefficient pair read from the bank picked by the
// one-hot ramF_enable. The enable is delayed to line up with the bank read
// latency. Pairs are buffered in a small FIFO and streamed out on valid/ready.
// The upstream address controller cannot stall, so a pair that arrives while
// the FIFO is full is dropped and flagged.
//
// Optional feature macro: COEFF_STREAMER_PARITY_EN. When it is defined, each
// FIFO entry stores an even-parity bit ^{data_a,data_b}, which is presented on
// out_parity.
//
// Ports
//   clk, reset_n          clock, synchronous active-low reset
//   in_ramF_enable        one-hot bank select from the address controller
//   in_ram_done           frame-end indication from the address controller
//   rd_data_a/rd_data_b   packed bank read data, bank k at [k*DATA_W +: DATA_W]
//   out_valid/out_ready   output stream handshake
//   out_data_a/b,out_last head-of-FIFO pair and its end-of-frame tag
//   fifo_count            FIFO occupancy
//   overflow              sticky: pair dropped on a full FIFO
//   sel_err               sticky: non-one-hot delayed enable during FILL
//   short_frame           sticky: frame ended early by in_ram_done
//   done                  frame fully drained; holds until reset
//   out_parity            (parity build only) parity of the head pair
module coeff_pair_streamer #(
    parameter int unsigned NUM_OF_ROM     = 32,
    parameter int unsigned RAMY_EN_LENGTH = 2**($clog2(128) - $clog2(NUM_OF_ROM)),
    parameter int unsigned DATA_W         = 16,
    parameter int unsigned RD_LATENCY     = 1,
    parameter int unsigned FIFO_DEPTH     = 8,
    parameter int unsigned PAIR_COUNT     = 256
) (
    input  logic                               clk,
    input  logic                               reset_n,
    input  logic [RAMY_EN_LENGTH-1:0]          in_ramF_enable,
    input  logic                               in_ram_done,
    input  logic [RAMY_EN_LENGTH*DATA_W-1:0]   rd_data_a,
    input  logic [RAMY_EN_LENGTH*DATA_W-1:0]   rd_data_b,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic [DATA_W-1:0]                  out_data_a,
    output logic [DATA_W-1:0]                  out_data_b,
    output logic                               out_last,
    output logic [$clog2(FIFO_DEPTH):0]        fifo_count,
    output logic                               overflow,
    output logic                               sel_err,
    output logic                               short_frame,
    output logic                               done
`ifdef COEFF_STREAMER_PARITY_EN
    ,
    output logic                               out_parity
`endif
);

    localparam int unsigned SEL_W  = RAMY_EN_LENGTH;
    localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W  = PTR_W + 1;
    localparam int unsigned PCNT_W = $clog2(PAIR_COUNT + 1);

    typedef enum logic [1:0] {IDLE, FILL, DRAIN, DONE} state_t;

    state_t state, state_nx;

    function automatic logic is_onehot(input logic [SEL_W-1:0] v);
        return (v != '0) && ((v & (v - SEL_W'(1))) == '0);
    endfunction

    // Enable delay line; the vld bit marks entries sampled inside the frame
    logic [SEL_W-1:0]      dly_en [RD_LATENCY];
    logic [RD_LATENCY-1:0] dly_vld;
    logic [SEL_W-1:0]      head_en;
    logic                  head_vld;

    logic [DATA_W-1:0]     mem_a [FIFO_DEPTH];
    logic [DATA_W-1:0]     mem_b [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] mem_last;
    logic [PTR_W-1:0]      wr_ptr, rd_ptr;
    logic [PCNT_W-1:0]     pair_cnt;

    logic                  track_c, push_c, last_c, retag_c, sel_set_c, short_set_c;
    logic                  pop_c, full_c, wr_en_c;
    logic [CNT_W-1:0]      count_nx_c;
    logic [DATA_W-1:0]     sel_a_c, sel_b_c;

    assign head_en  = dly_en[RD_LATENCY-1];
    assign head_vld = dly_vld[RD_LATENCY-1];

    // Bank select of the read data by the delayed enable
    always_comb begin
        sel_a_c = '0;
        sel_b_c = '0;
        for (int k = 0; k < int'(SEL_W); k++) begin
            if (head_en[k]) begin
                sel_a_c = rd_data_a[k*DATA_W +: DATA_W];
                sel_b_c = rd_data_b[k*DATA_W +: DATA_W];
            end
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nx;
    end

    // Next state and capture control; in_ram_done wins over the pending pair
    always_comb begin
        state_nx    = state;
        track_c     = 1'b0;
        push_c      = 1'b0;
        last_c      = 1'b0;
        retag_c     = 1'b0;
        sel_set_c   = 1'b0;
        short_set_c = 1'b0;
        case (state)
            IDLE: begin
                if (is_onehot(in_ramF_enable)) begin
                    track_c  = 1'b1;
                    state_nx = FILL;
                end
            end
            FILL: begin
                track_c = 1'b1;
                if (in_ram_done) begin
                    short_set_c = 1'b1;
                    retag_c     = 1'b1;
                    state_nx    = DRAIN;
                end else if (head_vld) begin
                    if (is_onehot(head_en)) begin
                        push_c = 1'b1;
                        if (pair_cnt == PCNT_W'(PAIR_COUNT - 1)) begin
                            last_c   = 1'b1;
                            state_nx = DRAIN;
                        end
                    end else begin
                        sel_set_c = 1'b1;
                    end
                end
            end
            DRAIN: begin
                if (fifo_count == '0) state_nx = DONE;
            end
            default: state_nx = DONE;
        endcase
    end

    // FIFO handshake arithmetic
    always_comb begin
        pop_c   = out_valid && out_ready;
        full_c  = (fifo_count == CNT_W'(FIFO_DEPTH));
        wr_en_c = push_c && (!full_c || pop_c);
        count_nx_c = fifo_count;
        if (wr_en_c && !pop_c)      count_nx_c = fifo_count + CNT_W'(1);
        else if (!wr_en_c && pop_c) count_nx_c = fifo_count - CNT_W'(1);
    end

    // Enable delay line
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < int'(RD_LATENCY); i++) dly_en[i] <= '0;
            dly_vld <= '0;
        end else begin
            dly_en[0]  <= track_c ? in_ramF_enable : '0;
            dly_vld[0] <= track_c;
            for (int i = 1; i < int'(RD_LATENCY); i++) begin
                dly_en[i]  <= dly_en[i-1];
                dly_vld[i] <= dly_vld[i-1];
            end
        end
    end

    // FIFO storage, pointers, counters and sticky flags
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                mem_a[i] <= '0;
                mem_b[i] <= '0;
            end
            mem_last    <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            fifo_count  <= '0;
            out_valid   <= 1'b0;
            pair_cnt    <= '0;
            overflow    <= 1'b0;
            sel_err     <= 1'b0;
            short_frame <= 1'b0;
            done        <= 1'b0;
        end else begin
            if (wr_en_c) begin
                mem_a[wr_ptr]    <= sel_a_c;
                mem_b[wr_ptr]    <= sel_b_c;
                mem_last[wr_ptr] <= last_c;
                wr_ptr           <= wr_ptr + PTR_W'(1);
            end
            // Early frame end: the newest buffered pair becomes the last one
            if (retag_c && (fifo_count != '0)) mem_last[wr_ptr - PTR_W'(1)] <= 1'b1;
            if (pop_c)  rd_ptr   <= rd_ptr + PTR_W'(1);
            if (push_c) pair_cnt <= pair_cnt + PCNT_W'(1);
            fifo_count <= count_nx_c;
            out_valid  <= (count_nx_c != '0);
            if (push_c && full_c && !pop_c) overflow <= 1'b1;
            if (sel_set_c)   sel_err     <= 1'b1;
            if (short_set_c) short_frame <= 1'b1;
            done <= (state_nx == DONE);
        end
    end

    assign out_data_a = mem_a[rd_ptr];
    assign out_data_b = mem_b[rd_ptr];
    assign out_last   = mem_last[rd_ptr];

`ifdef COEFF_STREAMER_PARITY_EN
    logic [FIFO_DEPTH-1:0] mem_par;

    // Even parity travels with each entry
    always_ff @(posedge clk) begin
        if (!reset_n)     mem_par         <= '0;
        else if (wr_en_c) mem_par[wr_ptr] <= ^{sel_a_c, sel_b_c};
    end

    assign out_parity = mem_par[rd_ptr];
`endif

endmodule

// File: tb/tb_coeff_pair_streamer.sv
// Directed bench for coeff_pair_streamer: full frame, backpressure/overflow,
// bad enables, early frame end, mid-frame reset, and read-latency alignment.
module tb_coeff_pair_streamer;

    localparam int unsigned DW = 16;
    localparam int unsigned NB = 4;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [NB-1:0] in_ramF_enable;
    logic          in_ram_done;
    logic [NB*DW-1:0] rd_data_a, rd_data_b;
    logic          out_ready;

    logic          out_valid, out_last, overflow, sel_err, short_frame, done;
    logic [DW-1:0] out_data_a, out_data_b;
    logic [3:0]    fifo_count;

    logic          out_valid3, out_last3, overflow3, sel_err3, short_frame3, done3;
    logic [DW-1:0] out_data_a3, out_data_b3;
    logic [3:0]    fifo_count3;

    int n_cmp = 0;
    int n_bad = 0;

    logic [DW-1:0] rx_a[$];
    logic [DW-1:0] rx_b[$];
    logic          rx_last[$];

    always #5 clk = ~clk;

    coeff_pair_streamer dut (
        .clk(clk), .reset_n(reset_n), .in_ramF_enable(in_ramF_enable),
        .in_ram_done(in_ram_done), .rd_data_a(rd_data_a), .rd_data_b(rd_data_b),
        .out_valid(out_valid), .out_ready(out_ready), .out_data_a(out_data_a),
        .out_data_b(out_data_b), .out_last(out_last), .fifo_count(fifo_count),
        .overflow(overflow), .sel_err(sel_err), .short_frame(short_frame), .done(done)
`ifdef COEFF_STREAMER_PARITY_EN
        , .out_parity()
`endif
    );

    coeff_pair_streamer #(.RD_LATENCY(3)) dut3 (
        .clk(clk), .reset_n(reset_n), .in_ramF_enable(in_ramF_enable),
        .in_ram_done(in_ram_done), .rd_data_a(rd_data_a), .rd_data_b(rd_data_b),
        .out_valid(out_valid3), .out_ready(out_ready), .out_data_a(out_data_a3),
        .out_data_b(out_data_b3), .out_last(out_last3), .fifo_count(fifo_count3),
        .overflow(overflow3), .sel_err(sel_err3), .short_frame(short_frame3), .done(done3)
`ifdef COEFF_STREAMER_PARITY_EN
        , .out_parity()
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Per-cycle unique data: bank k carries 0x4000+(tag<<4)+k / 0x8000+(tag<<4)+k
    task automatic drive_tag(input logic [NB-1:0] en, input int tag);
        in_ramF_enable = en;
        for (int k = 0; k < int'(NB); k++) begin
            rd_data_a[k*DW +: DW] = 16'(32'h4000 + (tag << 4) + k);
            rd_data_b[k*DW +: DW] = 16'(32'h8000 + (tag << 4) + k);
        end
    endtask

    // Fixed per-bank pattern 0x1000+k / 0x2000+k
    task automatic drive_const(input logic [NB-1:0] en);
        in_ramF_enable = en;
        for (int k = 0; k < int'(NB); k++) begin
            rd_data_a[k*DW +: DW] = 16'(32'h1000 + k);
            rd_data_b[k*DW +: DW] = 16'(32'h2000 + k);
        end
    endtask

    // Record the pair popped at the coming edge, then advance one cycle
    task automatic tick();
        if (out_valid && out_ready) begin
            rx_a.push_back(out_data_a);
            rx_b.push_back(out_data_b);
            rx_last.push_back(out_last);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n     = 1'b0;
        in_ram_done = 1'b0;
        out_ready   = 1'b0;
        drive_tag(4'b0000, 0);
        tick();
        reset_n = 1'b1;
        rx_a.delete();
        rx_b.delete();
        rx_last.delete();
    endtask

    task automatic wait_done(input int budget, input string tag);
        int i = 0;
        while (!done && i < budget) begin
            tick();
            i++;
        end
        check(tag, 32'(done), 32'd1);
    endtask

    function automatic int count_last();
        int s = 0;
        foreach (rx_last[i]) s += int'(rx_last[i]);
        return s;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset values
        do_reset();
        check("rst_valid", 32'(out_valid), 0);
        check("rst_count", 32'(fifo_count), 0);
        check("rst_data_a", 32'(out_data_a), 0);
        check("rst_last", 32'(out_last), 0);
        check("rst_flags", {28'd0, overflow, sel_err, short_frame, done}, 0);
        check("rst_valid3", 32'(out_valid3), 0);

        // Full frame, rotating banks, consumer always ready
        out_ready = 1'b1;
        for (int n = 0; n < 256; n++) begin
            drive_const(4'(1 << (n % 4)));
            tick();
        end
        drive_const(4'b0000);
        tick();
        wait_done(40, "t1_done");
        check("t1_rx_count", 32'(rx_a.size()), 256);
        for (int i = 0; i < rx_a.size(); i++) begin
            check($sformatf("t1_a[%0d]", i), 32'(rx_a[i]), 32'h1000 + 32'(i % 4));
            check($sformatf("t1_b[%0d]", i), 32'(rx_b[i]), 32'h2000 + 32'(i % 4));
            check($sformatf("t1_last[%0d]", i), 32'(rx_last[i]), (i == 255) ? 32'd1 : 32'd0);
        end
        check("t1_flags", {29'd0, overflow, sel_err, short_frame}, 0);

        // Backpressure: ready low for cycles 20..39, FIFO fills and overflows
        do_reset();
        for (int n = 0; n < 50; n++) begin
            drive_tag(4'b0001, n);
            out_ready = (n < 20 || n >= 40);
            if (n == 20) begin
                rx_a.delete();
                rx_b.delete();
                rx_last.delete();
            end
            if (n == 30) begin
                check("t2_count_full", 32'(fifo_count), 8);
                check("t2_overflow", 32'(overflow), 1);
                check("t2_valid_held", 32'(out_valid), 1);
                check("t2_head_a30", 32'(out_data_a), 32'h4130);
            end
            if (n == 39) check("t2_head_a39", 32'(out_data_a), 32'h4130);
            if (n == 41) check("t2_count_pushpop", 32'(fifo_count), 8);
            tick();
        end
        check("t2_rx_count", 32'(rx_a.size()), 10);
        if (rx_a.size() >= 10) begin
            check("t2_first", 32'(rx_a[0]), 32'h4130);
            check("t2_eighth", 32'(rx_a[7]), 32'h41A0);
            check("t2_ninth_a", 32'(rx_a[8]), 32'h4280);
            check("t2_ninth_b", 32'(rx_b[8]), 32'h8280);
            check("t2_tenth", 32'(rx_a[9]), 32'h4290);
        end

        // Multi-hot enable for 3 cycles, then early frame end with 5 pairs buffered
        do_reset();
        for (int n = 0; n < 10; n++) begin
            if (n <= 2 || n == 6 || n == 7) drive_tag(4'b0001, n);
            else if (n <= 5)                drive_tag(4'b0011, n);
            else                            drive_tag(4'b0000, n);
            in_ram_done = (n == 9);
            if (n == 7) check("t3_count_hold", 32'(fifo_count), 3);
            if (n == 9) check("t3_count", 32'(fifo_count), 5);
            tick();
        end
        in_ram_done = 1'b0;
        out_ready   = 1'b1;
        wait_done(40, "t3_done");
        check("t3_sel_err", 32'(sel_err), 1);
        check("t3_short", 32'(short_frame), 1);
        check("t3_overflow", 32'(overflow), 0);
        check("t3_rx_count", 32'(rx_a.size()), 5);
        if (rx_a.size() == 5) begin
            check("t3_p0", 32'(rx_a[0]), 32'h4010);
            check("t3_p2", 32'(rx_a[2]), 32'h4030);
            check("t3_p3", 32'(rx_a[3]), 32'h4070);
            check("t3_p4", 32'(rx_a[4]), 32'h4080);
            check("t3_last4", 32'(rx_last[4]), 1);
        end
        check("t3_last_total", 32'(count_last()), 1);

        // in_ram_done after 100 pairs; the last 5 are still buffered
        do_reset();
        for (int n = 0; n < 102; n++) begin
            if (n < 100) drive_tag(4'(1 << (n % 4)), n);
            else         drive_tag(4'b0000, n);
            out_ready   = (n < 97);
            in_ram_done = (n == 101);
            if (n == 101) check("t4_count", 32'(fifo_count), 5);
            tick();
        end
        in_ram_done = 1'b0;
        out_ready   = 1'b1;
        wait_done(40, "t4_done");
        check("t4_short", 32'(short_frame), 1);
        check("t4_sel_err", 32'(sel_err), 0);
        check("t4_rx_count", 32'(rx_a.size()), 100);
        if (rx_a.size() == 100) begin
            check("t4_first", 32'(rx_a[0]), 32'h4010);
            check("t4_p100_a", 32'(rx_a[99]), 32'h4643);
            check("t4_p100_last", 32'(rx_last[99]), 1);
        end
        check("t4_last_total", 32'(count_last()), 1);

        // Mid-frame reset with 5 pairs buffered and sel_err set
        do_reset();
        for (int n = 0; n < 7; n++) begin
            drive_tag((n <= 4) ? 4'b0001 : 4'b0000, n);
            tick();
        end
        check("t5_count_pre", 32'(fifo_count), 5);
        check("t5_sel_pre", 32'(sel_err), 1);
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        check("t5_valid", 32'(out_valid), 0);
        check("t5_count", 32'(fifo_count), 0);
        check("t5_data_a", 32'(out_data_a), 0);
        check("t5_flags", {28'd0, overflow, sel_err, short_frame, done}, 0);
        for (int n = 0; n < 3; n++) tick();
        check("t5_idle_sel", 32'(sel_err), 0);
        check("t5_idle_valid", 32'(out_valid), 0);
        drive_tag(4'b0010, 50);
        tick();
        tick();
        check("t5_restart_count", 32'(fifo_count), 1);
        check("t5_restart_a", 32'(out_data_a), 32'h4321);

        // Read latency alignment: enable at cycle 10
        do_reset();
        for (int n = 0; n < 16; n++) begin
            drive_tag((n == 10) ? 4'b0001 : 4'b0000, n);
            if (n == 11) check("t6_l1_valid11", 32'(out_valid), 0);
            if (n == 12) begin
                check("t6_l1_valid12", 32'(out_valid), 1);
                check("t6_l1_data", 32'(out_data_a), 32'h40B0);
            end
            if (n == 13) check("t6_l3_valid13", 32'(out_valid3), 0);
            if (n == 14) begin
                check("t6_l3_valid14", 32'(out_valid3), 1);
                check("t6_l3_data_a", 32'(out_data_a3), 32'h40D0);
                check("t6_l3_data_b", 32'(out_data_b3), 32'h80D0);
            end
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
